// File: rtl/conv_anchor_sched_pkg.sv
// Shared definitions for the convolution anchor scheduler.
//   state_t      : scheduler FSM states
//   COORD_W_DEF  : default coordinate / dimension / stride width
//   CNT_W_DEF    : default anchor counter width
//   cfg_rec_t    : latched job configuration {height, width, stride_h, stride_w}
//   cfg_is_valid : a job is runnable only if every field is non-zero
package conv_anchor_sched_pkg;

  localparam int COORD_W_DEF = 16;
  localparam int CNT_W_DEF   = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Stored at the default coordinate width; the top zero-extends narrower
  // COORD_W values into it, so COORD_W must not exceed COORD_W_DEF.
  typedef struct packed {
    logic [COORD_W_DEF-1:0] height;
    logic [COORD_W_DEF-1:0] width;
    logic [COORD_W_DEF-1:0] stride_h;
    logic [COORD_W_DEF-1:0] stride_w;
  } cfg_rec_t;

  function automatic logic cfg_is_valid(input cfg_rec_t c);
    return (c.height != '0) && (c.width != '0) &&
           (c.stride_h != '0) && (c.stride_w != '0);
  endfunction

endpackage

// File: rtl/conv_anchor_sched_step_counter.sv
// anchor_step_counter: one coordinate of the anchor raster.
//   clk, rst_n : clock, async active-low reset
//   clear      : load 0 (start of a job)
//   advance    : step the coordinate; wraps to 0 when the next step would
//                reach or pass the bound
//   step,bound : stride and dimension for this coordinate
//   value      : current coordinate
//   wrap       : value + step >= bound (this is the last position)
module anchor_step_counter
  import conv_anchor_sched_pkg::*;
#(
  parameter int W = COORD_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         advance,
  input  logic [W-1:0] step,
  input  logic [W-1:0] bound,
  output logic [W-1:0] value,
  output logic         wrap
);

  // One extra bit so value + step can never wrap past the bound.
  logic [W:0] next_sum;

  assign next_sum = {1'b0, value} + {1'b0, step};
  assign wrap     = (next_sum >= {1'b0, bound});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (advance) begin
      value <= wrap ? '0 : next_sum[W-1:0];
    end
  end

endmodule

// File: rtl/conv_anchor_sched.sv
// conv_anchor_sched: walks a raster of anchor coordinates over an image
// (column fastest) and hands them downstream over a valid/ready port.
//   clk, rst_n                        : clock, async active-low reset
//   start, abort                      : job request / job termination
//   cfg_height, cfg_width             : image extent (latched on start)
//   cfg_stride_h, cfg_stride_w        : anchor steps (latched on start)
//   busy, done, cfg_err               : status (done / cfg_err are pulses)
//   anc_valid, anc_ready              : anchor handshake
//   anc_row, anc_col, anc_last        : anchor coordinate and final marker
//   anc_count                         : anchors transferred in current/last job
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; config checked when start arrives
// RUN     | presenting anchors, advancing on each transfer
// DONE    | one-cycle done pulse after the last anchor transferred
module conv_anchor_sched
  import conv_anchor_sched_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [COORD_W-1:0] cfg_height,
  input  logic [COORD_W-1:0] cfg_width,
  input  logic [COORD_W-1:0] cfg_stride_h,
  input  logic [COORD_W-1:0] cfg_stride_w,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic               anc_valid,
  input  logic               anc_ready,
  output logic [COORD_W-1:0] anc_row,
  output logic [COORD_W-1:0] anc_col,
  output logic               anc_last,
  output logic [CNT_W-1:0]   anc_count
);

  state_t   state, state_d;
  cfg_rec_t cfg_in, cfg_q;

  logic start_ok;
  logic start_bad;
  logic transfer;
  logic col_adv;
  logic row_adv;
  logic col_wrap;
  logic row_wrap;

  assign cfg_in.height   = COORD_W_DEF'(cfg_height);
  assign cfg_in.width    = COORD_W_DEF'(cfg_width);
  assign cfg_in.stride_h = COORD_W_DEF'(cfg_stride_h);
  assign cfg_in.stride_w = COORD_W_DEF'(cfg_stride_w);

  // abort outranks start; a rejected start only reports when not aborted.
  assign start_ok  = (state == ST_IDLE) && start && !abort && cfg_is_valid(cfg_in);
  assign start_bad = (state == ST_IDLE) && start && !abort && !cfg_is_valid(cfg_in);

  assign transfer = anc_valid && anc_ready;

  // An aborted cycle never counts as a transfer, so anc_count holds.
  assign col_adv = transfer && !abort;
  // Row steps only when the column wraps, and holds on its final position.
  assign row_adv = col_adv && col_wrap && !row_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else if (start_ok) begin
      cfg_q <= cfg_in;
    end
  end

  anchor_step_counter #(.W(COORD_W)) u_col (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_ok),
    .advance (col_adv),
    .step    (COORD_W'(cfg_q.stride_w)),
    .bound   (COORD_W'(cfg_q.width)),
    .value   (anc_col),
    .wrap    (col_wrap)
  );

  anchor_step_counter #(.W(COORD_W)) u_row (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start_ok),
    .advance (row_adv),
    .step    (COORD_W'(cfg_q.stride_h)),
    .bound   (COORD_W'(cfg_q.height)),
    .value   (anc_row),
    .wrap    (row_wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort)                      state_d = ST_IDLE;
        else if (transfer && anc_last)  state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anc_count <= '0;
    end else if (start_ok) begin
      anc_count <= '0;
    end else if (col_adv) begin
      anc_count <= anc_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= start_bad;
    end
  end

  // Status outputs are decodes of the state register only; anc_last is built
  // from registered coordinates and latched config, never from inputs.
  assign anc_valid = (state == ST_RUN);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign anc_last  = anc_valid && col_wrap && row_wrap;

endmodule

// File: tb/tb_conv_anchor_sched.sv
module tb_conv_anchor_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] cfg_height;
  logic [15:0] cfg_width;
  logic [15:0] cfg_stride_h;
  logic [15:0] cfg_stride_w;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic        anc_valid;
  logic        anc_ready;
  logic [15:0] anc_row;
  logic [15:0] anc_col;
  logic        anc_last;
  logic [31:0] anc_count;

  int pass_cnt   = 0;
  int total_cnt  = 0;
  int last_count = 0;

  always #5 clk = ~clk;

  conv_anchor_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cfg_height   (cfg_height),
    .cfg_width    (cfg_width),
    .cfg_stride_h (cfg_stride_h),
    .cfg_stride_w (cfg_stride_w),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err),
    .anc_valid    (anc_valid),
    .anc_ready    (anc_ready),
    .anc_row      (anc_row),
    .anc_col      (anc_col),
    .anc_last     (anc_last),
    .anc_count    (anc_count)
  );

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; anc_ready = 1'b0;
    cfg_height = '0; cfg_width = '0; cfg_stride_h = '0; cfg_stride_w = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({busy, done, cfg_err, anc_valid, anc_row, anc_col, anc_last, anc_count} !== 68'd0)
      $display("FAIL reset_outputs got busy=%b done=%b err=%b valid=%b row=%0d col=%0d last=%b cnt=%0d want all 0",
               busy, done, cfg_err, anc_valid, anc_row, anc_col, anc_last, anc_count);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Runs one job and checks every presented anchor against the raster model.
  // rnd=1 toggles anc_ready randomly and throws ignored start pulses.
  task automatic run_job(input int h, input int w, input int sh, input int sw,
                         input bit rnd, input string name);
    int exp_r, exp_c, n, total;
    bit fin, rdy, exp_last;
    total = ((h + sh - 1) / sh) * ((w + sw - 1) / sw);
    exp_r = 0; exp_c = 0; n = 0; fin = 1'b0;
    cfg_height = 16'(h); cfg_width = 16'(w);
    cfg_stride_h = 16'(sh); cfg_stride_w = 16'(sw);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Latched config must be immune to later input changes.
    cfg_height = 16'd1; cfg_width = 16'd1; cfg_stride_h = 16'd1; cfg_stride_w = 16'd1;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      if (n < total) begin
        exp_last = ((exp_c + sw) >= w) && ((exp_r + sh) >= h);
        total_cnt++;
        if ({busy, done, anc_valid, anc_row, anc_col, anc_last, anc_count} !==
            {1'b1, 1'b0, 1'b1, 16'(exp_r), 16'(exp_c), exp_last, 32'(n)})
          $display("FAIL %s anchor%0d got busy=%b done=%b valid=%b row=%0d col=%0d last=%b cnt=%0d want 1 0 1 row=%0d col=%0d last=%b cnt=%0d",
                   name, n, busy, done, anc_valid, anc_row, anc_col, anc_last, anc_count,
                   exp_r, exp_c, exp_last, n);
        else pass_cnt++;
        rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        anc_ready = rdy;
        if (rnd) start = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (rdy) begin
          n++;
          if (exp_c + sw < w) exp_c = exp_c + sw;
          else begin
            exp_c = 0;
            if (exp_r + sh < h) exp_r = exp_r + sh;
          end
        end
      end else begin
        start = 1'b0;
        anc_ready = 1'b0;
        total_cnt++;
        if ({done, busy, anc_valid, anc_last, anc_count} !== {1'b1, 1'b1, 1'b0, 1'b0, 32'(total)})
          $display("FAIL %s done_cycle got done=%b busy=%b valid=%b last=%b cnt=%0d want 1 1 0 0 cnt=%0d",
                   name, done, busy, anc_valid, anc_last, anc_count, total);
        else pass_cnt++;
        fin = 1'b1;
      end
    end
    start = 1'b0;
    anc_ready = 1'b0;
    if (!fin) begin
      total_cnt++;
      $display("FAIL %s timeout got %0d transfers want %0d", name, n, total);
    end
    @(negedge clk);
    total_cnt++;
    if ({done, busy, anc_valid, anc_count} !== {1'b0, 1'b0, 1'b0, 32'(total)})
      $display("FAIL %s after_done got done=%b busy=%b valid=%b cnt=%0d want 0 0 0 cnt=%0d",
               name, done, busy, anc_valid, anc_count, total);
    else pass_cnt++;
    last_count = total;
  endtask

  task automatic test_basic();
    run_job(4, 4, 1, 1, 1'b0, "job4x4");
  endtask

  task automatic test_strides();
    run_job(5, 5, 2, 2, 1'b0, "job5x5_s2");
    run_job(3, 7, 1, 8, 1'b0, "job3x7_sw8");
  endtask

  task automatic test_backpressure();
    run_job(4, 4, 1, 1, 1'b1, "job4x4_stall");
  endtask

  task automatic test_abort();
    cfg_height = 16'd4; cfg_width = 16'd4; cfg_stride_h = 16'd1; cfg_stride_w = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    anc_ready = 1'b1;
    repeat (5) @(negedge clk);
    total_cnt++;
    if ({busy, anc_valid, anc_count} !== {1'b1, 1'b1, 32'd5})
      $display("FAIL abort_pre got busy=%b valid=%b cnt=%0d want 1 1 cnt=5", busy, anc_valid, anc_count);
    else pass_cnt++;
    abort = 1'b1;  // ready stays high: the aborted cycle must not count
    @(negedge clk);
    abort = 1'b0;
    anc_ready = 1'b0;
    total_cnt++;
    if ({busy, anc_valid, done, anc_count} !== {1'b0, 1'b0, 1'b0, 32'd5})
      $display("FAIL abort_idle got busy=%b valid=%b done=%b cnt=%0d want 0 0 0 cnt=5",
               busy, anc_valid, done, anc_count);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if ({done, busy, anc_count} !== {1'b0, 1'b0, 32'd5})
        $display("FAIL abort_quiet%0d got done=%b busy=%b cnt=%0d want 0 0 cnt=5", i, done, busy, anc_count);
      else pass_cnt++;
    end
    run_job(4, 4, 1, 1, 1'b0, "job_after_abort");
  endtask

  task automatic test_cfg_err();
    cfg_height = 16'd4; cfg_width = 16'd4; cfg_stride_h = 16'd0; cfg_stride_w = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total_cnt++;
    if ({cfg_err, busy, anc_valid, anc_count} !== {1'b1, 1'b0, 1'b0, 32'(last_count)})
      $display("FAIL cfg_err_pulse got err=%b busy=%b valid=%b cnt=%0d want 1 0 0 cnt=%0d",
               cfg_err, busy, anc_valid, anc_count, last_count);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({cfg_err, busy} !== 2'b00)
      $display("FAIL cfg_err_clear got err=%b busy=%b want 0 0", cfg_err, busy);
    else pass_cnt++;
    cfg_stride_h = 16'd1;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    total_cnt++;
    if ({busy, anc_valid, cfg_err, anc_count} !== {1'b0, 1'b0, 1'b0, 32'(last_count)})
      $display("FAIL start_abort got busy=%b valid=%b err=%b cnt=%0d want 0 0 0 cnt=%0d",
               busy, anc_valid, cfg_err, anc_count, last_count);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({busy, anc_valid} !== 2'b00)
      $display("FAIL start_abort_hold got busy=%b valid=%b want 0 0", busy, anc_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_job();
    cfg_height = 16'd4; cfg_width = 16'd4; cfg_stride_h = 16'd1; cfg_stride_w = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    anc_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy, done, cfg_err, anc_valid, anc_row, anc_col, anc_last, anc_count} !== 68'd0)
      $display("FAIL reset_mid got busy=%b done=%b err=%b valid=%b row=%0d col=%0d last=%b cnt=%0d want all 0",
               busy, done, cfg_err, anc_valid, anc_row, anc_col, anc_last, anc_count);
    else pass_cnt++;
    anc_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_job(4, 4, 1, 1, 1'b0, "job_after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_strides();
    test_backpressure();
    test_abort();
    test_cfg_err();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
